mem_ref_ctrl: RTL and testbench

MEM_REF_CTRL -- requirements
Module: mem_ref_ctrl

---
 rtl/mem_ref_ctrl_if.sv | 40 ++++
 rtl/mem_ref_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_ref_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ref_ctrl_if.sv
// Control bus of the multi-cycle memory-reference controller.
// The controller side uses modport master: it receives the instruction word
// and flags and drives every datapath strobe and select.
// The datapath (or a testbench) uses modport slave.
interface mem_ref_ctrl_if;
    logic [31:0] I;
    logic [3:0]  NZCV;
    logic        Write_PC;
    logic        Write_IR;
    logic        Write_Reg;
    logic        LA;
    logic        LB;
    logic        LC;
    logic        LF;
    logic        S;
    logic [3:0]  ALU_OP;
    logic [1:0]  PC_s;
    logic [1:0]  W_Rdata_s;
    logic        rd_s;
    logic        ALU_A_s;
    logic        ALU_B_s;
    logic        Reg_C_s;
    logic        Mem_Write;
    logic        Mem_W_s;
    logic [3:0]  state;

    modport master (
        input  I, NZCV,
        output Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, ALU_OP,
               PC_s, W_Rdata_s, rd_s, ALU_A_s, ALU_B_s, Reg_C_s,
               Mem_Write, Mem_W_s, state
    );

    modport slave (
        output I, NZCV,
        input  Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, ALU_OP,
               PC_s, W_Rdata_s, rd_s, ALU_A_s, ALU_B_s, Reg_C_s,
               Mem_Write, Mem_W_s, state
    );
endinterface

// File: rtl/mem_ref_ctrl.sv
// mem_ref_ctrl: multi-cycle control FSM for an ARM-like datapath covering
// data processing, LDR/STR with immediate offset, and B/BL.
// Optional feature macro: COND_EXEC_EN -- when defined, DECODE checks the
// instruction condition field I[31:28] against NZCV; when undefined, every
// instruction executes and I[31:28]/NZCV are ignored.
// All outputs are combinational decodes of the state register and I; the
// strobes are forced low while Rst is high so no partial write can complete.
module mem_ref_ctrl (
    input  logic           clk,
    input  logic           Rst,
    mem_ref_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_WB_DP  = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_WB_LD  = 4'd6,
        ST_MEM_WR = 4'd7,
        ST_BRANCH = 4'd8
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        cond_ok_s;

    logic        write_pc_s;
    logic        write_ir_s;
    logic        write_reg_s;
    logic        la_s;
    logic        lb_s;
    logic        lc_s;
    logic        lf_s;
    logic        s_s;
    logic [3:0]  alu_op_s;
    logic [1:0]  pc_sel_s;
    logic [1:0]  w_rdata_sel_s;
    logic        rd_sel_s;
    logic        alu_a_sel_s;
    logic        alu_b_sel_s;
    logic        reg_c_sel_s;
    logic        mem_write_s;
    logic        mem_w_sel_s;
    logic        unused_ok_s;

`ifdef COND_EXEC_EN
    // ARM condition table; the reserved code 1111 never executes
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign cond_ok_s   = cond_pass(bus.I[31:28], bus.NZCV);
    assign unused_ok_s = &{1'b0, bus.I[19:0]};
`else
    assign cond_ok_s   = 1'b1;
    assign unused_ok_s = &{1'b0, bus.I[31:28], bus.I[19:0], bus.NZCV};
`endif

    // State register; reset returns to FETCH immediately, independent of clk
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode; everything defaults to 0
    always_comb begin
        state_d       = ST_FETCH;
        write_pc_s    = 1'b0;
        write_ir_s    = 1'b0;
        write_reg_s   = 1'b0;
        la_s          = 1'b0;
        lb_s          = 1'b0;
        lc_s          = 1'b0;
        lf_s          = 1'b0;
        s_s           = 1'b0;
        alu_op_s      = 4'b0000;
        pc_sel_s      = 2'b00;
        w_rdata_sel_s = 2'b00;
        rd_sel_s      = 1'b0;
        alu_a_sel_s   = 1'b0;
        alu_b_sel_s   = 1'b0;
        reg_c_sel_s   = 1'b0;
        mem_write_s   = 1'b0;
        mem_w_sel_s   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                write_ir_s = 1'b1;
                write_pc_s = 1'b1;
                pc_sel_s   = 2'b00;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                la_s = 1'b1;
                lb_s = 1'b1;
                lc_s = 1'b1;
                // Stores read Rd on port C as the data to write
                if (bus.I[27:26] == 2'b01) begin
                    reg_c_sel_s = 1'b1;
                end else begin
                    reg_c_sel_s = 1'b0;
                end
                if (!cond_ok_s) begin
                    state_d = ST_FETCH;
                end else if (bus.I[27:26] == 2'b00) begin
                    state_d = ST_EXEC;
                end else if (bus.I[27:26] == 2'b01) begin
                    state_d = ST_ADDR;
                end else if (bus.I[27:25] == 3'b101) begin
                    state_d = ST_BRANCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                alu_op_s = bus.I[24:21];
                s_s      = bus.I[20];
                lf_s     = 1'b1;
                // TST/TEQ/CMP/CMN only update flags, no register writeback
                if (bus.I[24:23] == 2'b10) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB_DP;
                end
            end
            ST_WB_DP: begin
                write_reg_s   = 1'b1;
                w_rdata_sel_s = 2'b00;
                rd_sel_s      = 1'b0;
                state_d       = ST_FETCH;
            end
            ST_ADDR: begin
                alu_b_sel_s = 1'b1;
                lf_s        = 1'b1;
                // U bit selects add or subtract of the 12-bit offset
                if (bus.I[23]) begin
                    alu_op_s = 4'b0100;
                end else begin
                    alu_op_s = 4'b0010;
                end
                if (bus.I[20]) begin
                    state_d = ST_MEM_RD;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                mem_w_sel_s = 1'b1;
                state_d     = ST_WB_LD;
            end
            ST_WB_LD: begin
                write_reg_s   = 1'b1;
                w_rdata_sel_s = 2'b01;
                state_d       = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_s = 1'b1;
                mem_w_sel_s = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_BRANCH: begin
                write_pc_s = 1'b1;
                pc_sel_s   = 2'b01;
                // BL additionally saves the return address into R14
                if (bus.I[24]) begin
                    write_reg_s   = 1'b1;
                    rd_sel_s      = 1'b1;
                    w_rdata_sel_s = 2'b10;
                end else begin
                    write_reg_s   = 1'b0;
                    rd_sel_s      = 1'b0;
                    w_rdata_sel_s = 2'b00;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Strobes are gated by Rst so nothing fires while reset is held
    assign bus.Write_PC  = write_pc_s  & ~Rst;
    assign bus.Write_IR  = write_ir_s  & ~Rst;
    assign bus.Write_Reg = write_reg_s & ~Rst;
    assign bus.LA        = la_s        & ~Rst;
    assign bus.LB        = lb_s        & ~Rst;
    assign bus.LC        = lc_s        & ~Rst;
    assign bus.LF        = lf_s        & ~Rst;
    assign bus.S         = s_s         & ~Rst;
    assign bus.Mem_Write = mem_write_s & ~Rst;
    assign bus.ALU_OP    = alu_op_s;
    assign bus.PC_s      = pc_sel_s;
    assign bus.W_Rdata_s = w_rdata_sel_s;
    assign bus.rd_s      = rd_sel_s;
    assign bus.ALU_A_s   = alu_a_sel_s;
    assign bus.ALU_B_s   = alu_b_sel_s;
    assign bus.Reg_C_s   = reg_c_sel_s;
    assign bus.Mem_W_s   = mem_w_sel_s;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mem_ref_ctrl.sv
// Scoreboard bench for mem_ref_ctrl. The stimulus process sets I/NZCV and
// queues one hand-built expected output word per clock cycle; the monitor
// pops and compares on every falling edge (or on demand for asynchronous
// reset checks).
// Word layout: {state[3:0], WPC, WIR, WREG, LA, LB, LC, LF, S, ALU_OP[3:0],
//               PC_s[1:0], W_Rdata_s[1:0], rd_s, ALU_A_s, ALU_B_s, Reg_C_s,
//               Mem_Write, Mem_W_s}
module tb_mem_ref_ctrl;

    typedef struct {
        string       name;
        logic [25:0] v;
    } exp_t;

    logic clk;
    logic Rst;
    mem_ref_ctrl_if bus ();

    mem_ref_ctrl dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.master)
    );

    exp_t exp_q[$];
    int   n_vec;
    int   n_miss;
    event sample_now;

    exp_t        mon_e;
    logic [25:0] mon_act;

    logic [25:0] V_RST, V_F, V_D0, V_D1;
    logic [25:0] V_EX_ADD, V_EX_ADDS, V_EX_CMP, V_WB_DP;
    logic [25:0] V_ADDR_ADD, V_ADDR_SUB, V_MEM_RD, V_WB_LD, V_MEM_WR;
    logic [25:0] V_BR_BL, V_BR_B;

    function automatic logic [25:0] mk(input logic [3:0] st, input logic [7:0] strb,
                                       input logic [3:0] alu, input logic [1:0] pcs,
                                       input logic [1:0] wds, input logic [5:0] sel);
        return {st, strb, alu, pcs, wds, sel};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares the DUT output word against the scoreboard head
    always begin
        @(negedge clk or sample_now);
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {bus.state, bus.Write_PC, bus.Write_IR, bus.Write_Reg,
                       bus.LA, bus.LB, bus.LC, bus.LF, bus.S, bus.ALU_OP,
                       bus.PC_s, bus.W_Rdata_s, bus.rd_s, bus.ALU_A_s,
                       bus.ALU_B_s, bus.Reg_C_s, bus.Mem_Write, bus.Mem_W_s};
            n_vec++;
            if (mon_act !== mon_e.v) begin
                n_miss++;
                $display("FAIL %s: actual=%07h required=%07h", mon_e.name, mon_act, mon_e.v);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [25:0] v);
        exp_t e;
        e.name = nm;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        V_RST      = mk(4'd0, 8'b0000_0000, 4'b0000, 2'b00, 2'b00, 6'b000000);
        V_F        = mk(4'd0, 8'b1100_0000, 4'b0000, 2'b00, 2'b00, 6'b000000);
        V_D0       = mk(4'd1, 8'b0001_1100, 4'b0000, 2'b00, 2'b00, 6'b000000);
        V_D1       = mk(4'd1, 8'b0001_1100, 4'b0000, 2'b00, 2'b00, 6'b000100);
        V_EX_ADD   = mk(4'd2, 8'b0000_0010, 4'b0100, 2'b00, 2'b00, 6'b000000);
        V_EX_ADDS  = mk(4'd2, 8'b0000_0011, 4'b0100, 2'b00, 2'b00, 6'b000000);
        V_EX_CMP   = mk(4'd2, 8'b0000_0011, 4'b1010, 2'b00, 2'b00, 6'b000000);
        V_WB_DP    = mk(4'd3, 8'b0010_0000, 4'b0000, 2'b00, 2'b00, 6'b000000);
        V_ADDR_ADD = mk(4'd4, 8'b0000_0010, 4'b0100, 2'b00, 2'b00, 6'b001000);
        V_ADDR_SUB = mk(4'd4, 8'b0000_0010, 4'b0010, 2'b00, 2'b00, 6'b001000);
        V_MEM_RD   = mk(4'd5, 8'b0000_0000, 4'b0000, 2'b00, 2'b00, 6'b000001);
        V_WB_LD    = mk(4'd6, 8'b0010_0000, 4'b0000, 2'b00, 2'b01, 6'b000000);
        V_MEM_WR   = mk(4'd7, 8'b0000_0000, 4'b0000, 2'b00, 2'b00, 6'b000011);
        V_BR_BL    = mk(4'd8, 8'b1010_0000, 4'b0000, 2'b01, 2'b10, 6'b100000);
        V_BR_B     = mk(4'd8, 8'b1000_0000, 4'b0000, 2'b01, 2'b00, 6'b000000);

        Rst      = 1'b1;
        bus.I    = 32'h0000_0000;
        bus.NZCV = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        push_exp("rst_hold", V_RST);
        go(1);

        // ADD R2,R1,R3: FETCH, DECODE, EXEC, WB_DP
        bus.I = 32'hE081_2003;
        Rst   = 1'b0;
        push_exp("add_fetch", V_F);
        push_exp("add_decode", V_D0);
        push_exp("add_exec", V_EX_ADD);
        push_exp("add_wb", V_WB_DP);
        go(4);

        // ADDS: same path with S raised in EXEC
        bus.I = 32'hE091_2003;
        push_exp("adds_fetch", V_F);
        push_exp("adds_decode", V_D0);
        push_exp("adds_exec", V_EX_ADDS);
        push_exp("adds_wb", V_WB_DP);
        go(4);

        // CMP R2,R3: no writeback, 3 cycles
        bus.I = 32'hE152_0003;
        push_exp("cmp_fetch", V_F);
        push_exp("cmp_decode", V_D0);
        push_exp("cmp_exec", V_EX_CMP);
        go(3);

        // LDR R2,[R1,#4]: 5 cycles
        bus.I = 32'hE591_2004;
        push_exp("ldr_fetch", V_F);
        push_exp("ldr_decode", V_D1);
        push_exp("ldr_addr", V_ADDR_ADD);
        push_exp("ldr_memrd", V_MEM_RD);
        push_exp("ldr_wbld", V_WB_LD);
        go(5);

        // STR R2,[R1,#-4]: 4 cycles
        bus.I = 32'hE501_2004;
        push_exp("str_fetch", V_F);
        push_exp("str_decode", V_D1);
        push_exp("str_addr", V_ADDR_SUB);
        push_exp("str_memwr", V_MEM_WR);
        go(4);

        // BL and B: 3 cycles each
        bus.I = 32'hEB00_0002;
        push_exp("bl_fetch", V_F);
        push_exp("bl_decode", V_D0);
        push_exp("bl_branch", V_BR_BL);
        go(3);
        bus.I = 32'hEA00_0002;
        push_exp("b_fetch", V_F);
        push_exp("b_decode", V_D0);
        push_exp("b_branch", V_BR_B);
        go(3);

        // Undefined encodings (I[27:25]=111 and 110): 2 cycles
        bus.I = 32'hEF00_0000;
        push_exp("und7_fetch", V_F);
        push_exp("und7_decode", V_D0);
        go(2);
        bus.I = 32'hEC00_0000;
        push_exp("und6_fetch", V_F);
        push_exp("und6_decode", V_D0);
        go(2);

        // ADDEQ with Z clear, then Z set, then the reserved condition 1111
        bus.I    = 32'h0081_2003;
        bus.NZCV = 4'b0000;
        push_exp("addeq_z0_fetch", V_F);
        push_exp("addeq_z0_decode", V_D0);
`ifdef COND_EXEC_EN
        go(2);
`else
        push_exp("addeq_z0_exec", V_EX_ADD);
        push_exp("addeq_z0_wb", V_WB_DP);
        go(4);
`endif
        bus.NZCV = 4'b0100;
        push_exp("addeq_z1_fetch", V_F);
        push_exp("addeq_z1_decode", V_D0);
        push_exp("addeq_z1_exec", V_EX_ADD);
        push_exp("addeq_z1_wb", V_WB_DP);
        go(4);
        bus.I = 32'hF081_2003;
        push_exp("nv_fetch", V_F);
        push_exp("nv_decode", V_D0);
`ifdef COND_EXEC_EN
        go(2);
`else
        push_exp("nv_exec", V_EX_ADD);
        push_exp("nv_wb", V_WB_DP);
        go(4);
`endif
        bus.NZCV = 4'b0000;

        // Reset pulsed during MEM_WR of an STR
        bus.I = 32'hE501_2004;
        push_exp("strr_fetch", V_F);
        push_exp("strr_decode", V_D1);
        push_exp("strr_addr", V_ADDR_SUB);
        push_exp("strr_memwr", V_MEM_WR);
        go(3);
        @(negedge clk);
        #1;
        Rst = 1'b1;
        #1;
        push_exp("strr_rst_async", V_RST);
        -> sample_now;
        #1;
        push_exp("strr_rst_held", V_RST);
        go(2);
        Rst = 1'b0;
        push_exp("strr_release_fetch", V_F);
        push_exp("strr_release_decode", V_D1);
        push_exp("strr_release_addr", V_ADDR_SUB);
        push_exp("strr_release_memwr", V_MEM_WR);
        go(4);

        go(2);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
